// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU opcodes, FSM states.
package ex_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned CountWidth = 4;

    // Codes 11-15 are unassigned and execute as ADD.
    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluMul  = 4'd9,
        AluPass = 4'd10
    } aluop_e;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } ex_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps,
// low WIDTH bits of the product returned on the cycle of the last step.
module seq_multiplier
    import ex_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done
);

    logic                  run_q, run_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]      mplier_q, mplier_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      acc_step;

    // Next-state for the step datapath; product is taken from the post-step accumulator
    // so the final step's partial product is included on the done cycle.
    always_comb begin
        run_d    = run_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = run_q && (count_q == '1);
        product  = acc_step;

        if (abort) begin
            run_d   = 1'b0;
            count_d = '0;
        end else if (run_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            if (done) begin
                run_d = 1'b0;
            end
        end else if (start) begin
            run_d    = 1'b1;
            count_d  = '0;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
        end
    end

    // Step state register; reset clears any partial product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= 1'b0;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            run_q    <= run_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/ex_cycle.sv
// Execute stage: operand select, single-cycle ALU, iterative multiply, EX/MEM register.
module ex_cycle
    import ex_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             alusrc,
    input  logic [3:0]       aluop,
    input  logic             memwrite_in,
    input  logic             regwrite_in,
    input  logic             flush,
    output logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] bout,
    output logic             memwrite,
    output logic             regwrite,
    output logic             zero,
    output logic             stall
);

    ex_state_e        state_q, state_d;
    logic [WIDTH-1:0] op2;
    logic [3:0]       shamt;
    logic [WIDTH-1:0] alu_res;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic [WIDTH-1:0] bout_q, bout_d;
    logic             memwrite_q, memwrite_d;
    logic             regwrite_q, regwrite_d;
    logic             zero_q, zero_d;
    // Store data and control captured at MUL issue, written back when the product is ready.
    logic [WIDTH-1:0] b_lat_q, b_lat_d;
    logic             mw_lat_q, mw_lat_d;
    logic             rw_lat_q, rw_lat_d;

    assign op2       = alusrc ? imm : b;
    assign shamt     = op2[3:0];
    assign is_mul    = (aluop == AluMul);
    assign mul_start = (state_q == StIdle) && is_mul && !flush;

    // Single-cycle ALU; MUL and unassigned codes fall into the ADD default.
    always_comb begin
        alu_res = a + op2;
        case (aluop)
            AluSub:  alu_res = a - op2;
            AluAnd:  alu_res = a & op2;
            AluOr:   alu_res = a | op2;
            AluXor:  alu_res = a ^ op2;
            AluSll:  alu_res = a << shamt;
            AluSrl:  alu_res = a >> shamt;
            AluSra:  alu_res = $unsigned($signed(a) >>> shamt);
            AluSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(op2))};
            AluPass: alu_res = op2;
            default: alu_res = a + op2;
        endcase
    end

    seq_multiplier u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (flush),
        .a       (a),
        .b       (op2),
        .product (mul_product),
        .done    (mul_done)
    );

    // Stall holds upstream during issue and all but the last multiply step; reset and
    // flush both release it.
    always_comb begin
        stall = 1'b0;
        if (rst && !flush) begin
            stall = ((state_q == StIdle) && is_mul) || ((state_q == StBusy) && !mul_done);
        end
    end

    // FSM and EX/MEM next-state; the default is a bubble (values held, enables cleared).
    always_comb begin
        state_d    = state_q;
        aluout_d   = aluout_q;
        bout_d     = bout_q;
        memwrite_d = 1'b0;
        regwrite_d = 1'b0;
        zero_d     = zero_q;
        b_lat_d    = b_lat_q;
        mw_lat_d   = mw_lat_q;
        rw_lat_d   = rw_lat_q;

        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_mul) begin
                        state_d  = StBusy;
                        b_lat_d  = b;
                        mw_lat_d = memwrite_in;
                        rw_lat_d = regwrite_in;
                    end else begin
                        aluout_d   = alu_res;
                        bout_d     = b;
                        memwrite_d = memwrite_in;
                        regwrite_d = regwrite_in;
                        zero_d     = (alu_res == '0);
                    end
                end
                StBusy: begin
                    if (mul_done) begin
                        state_d    = StIdle;
                        aluout_d   = mul_product;
                        bout_d     = b_lat_q;
                        memwrite_d = mw_lat_q;
                        regwrite_d = rw_lat_q;
                        zero_d     = (mul_product == '0);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // EX/MEM register, FSM state and latched MUL side-band.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            aluout_q   <= '0;
            bout_q     <= '0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            zero_q     <= 1'b0;
            b_lat_q    <= '0;
            mw_lat_q   <= 1'b0;
            rw_lat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            aluout_q   <= aluout_d;
            bout_q     <= bout_d;
            memwrite_q <= memwrite_d;
            regwrite_q <= regwrite_d;
            zero_q     <= zero_d;
            b_lat_q    <= b_lat_d;
            mw_lat_q   <= mw_lat_d;
            rw_lat_q   <= rw_lat_d;
        end
    end

    assign aluout   = aluout_q;
    assign bout     = bout_q;
    assign memwrite = memwrite_q;
    assign regwrite = regwrite_q;
    assign zero     = zero_q;

endmodule
